operand_fetch: RTL and testbench

- Read-side initiator for the register bank. Accepts decoded instructions, tracks pending destination writes in a per-register scoreboard, and stalls on read-after-write hazards.
- Once operands are safe, it drives the bank's read ports A/B and captures the registered read data one cycle later.
- Presents operands downstream with a valid/ready handshake. Sits between decode and execute.

---
 rtl/operand_fetch_if.sv | 54 +++++
 rtl/operand_fetch.sv | 150 +++++++++++++++
 tb/tb_operand_fetch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Bundle between operand_fetch and its neighbours: decode issue, register-bank
// read ports, writeback snoop and the downstream operand handshake.
interface operand_fetch_if #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32
);
  localparam int AW = $clog2(NUMREGS);

  logic                 issue_valid_i;
  logic                 issue_ready_o;
  logic [AW-1:0]        rs1_i;
  logic [AW-1:0]        rs2_i;
  logic                 use_rs1_i;
  logic                 use_rs2_i;
  logic [AW-1:0]        rd_i;
  logic                 rd_we_i;

  logic                 re_a_o;
  logic                 re_b_o;
  logic [AW-1:0]        raddr_a_o;
  logic [AW-1:0]        raddr_b_o;
  logic [DATAWIDTH-1:0] rdata_a_i;
  logic [DATAWIDTH-1:0] rdata_b_i;

  logic                 wb_valid_i;
  logic [AW-1:0]        wb_addr_i;

  logic                 op_valid_o;
  logic                 op_ready_i;
  logic [DATAWIDTH-1:0] op_a_o;
  logic [DATAWIDTH-1:0] op_b_o;
  logic [AW-1:0]        op_rd_o;
  logic                 op_rd_we_o;

  modport slave (
    input  issue_valid_i, rs1_i, rs2_i, use_rs1_i, use_rs2_i, rd_i, rd_we_i,
    output issue_ready_o,
    output re_a_o, re_b_o, raddr_a_o, raddr_b_o,
    input  rdata_a_i, rdata_b_i,
    input  wb_valid_i, wb_addr_i,
    output op_valid_o, op_a_o, op_b_o, op_rd_o, op_rd_we_o,
    input  op_ready_i
  );

  modport master (
    output issue_valid_i, rs1_i, rs2_i, use_rs1_i, use_rs2_i, rd_i, rd_we_i,
    input  issue_ready_o,
    input  re_a_o, re_b_o, raddr_a_o, raddr_b_o,
    output rdata_a_i, rdata_b_i,
    output wb_valid_i, wb_addr_i,
    input  op_valid_o, op_a_o, op_b_o, op_rd_o, op_rd_we_o,
    output op_ready_i
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboards pending destination writes, stalls on RAW
// hazards, reads the register bank and hands operands to execute.
module operand_fetch #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  operand_fetch_if.slave   bus
);
  localparam int AW = $clog2(NUMREGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DATA  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]        rs1_q, rs2_q, rd_q;
  logic                 use_rs1_q, use_rs2_q, rd_we_q;
  logic [NUMREGS-1:0]   busy_q, busy_d;
  logic [DATAWIDTH-1:0] op_a_q, op_b_q;
  logic [AW-1:0]        op_rd_q;
  logic                 op_rd_we_q;

  logic                 ready;
  logic                 latch_en;
  logic                 capture_en;
  logic                 go;
  logic                 re_a, re_b;
  logic [AW-1:0]        raddr_a, raddr_b;
  logic                 hazard_a, hazard_b, hazard;
  logic                 rs1_live, rs2_live;

  assign rs1_live = use_rs1_q && (rs1_q != '0);
  assign rs2_live = use_rs2_q && (rs2_q != '0);

  // A writeback landing this cycle clears the hazard: the bank forwards
  // same-cycle writes onto its read ports.
  assign hazard_a = rs1_live && busy_q[rs1_q] &&
                    !(bus.wb_valid_i && (bus.wb_addr_i == rs1_q));
  assign hazard_b = rs2_live && busy_q[rs2_q] &&
                    !(bus.wb_valid_i && (bus.wb_addr_i == rs2_q));
  assign hazard   = hazard_a || hazard_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    go         = 1'b0;
    re_a       = 1'b0;
    re_b       = 1'b0;
    raddr_a    = '0;
    raddr_b    = '0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.issue_valid_i) begin
          latch_en = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (!hazard) begin
          go      = 1'b1;
          re_a    = use_rs1_q;
          raddr_a = rs1_q;
          re_b    = use_rs2_q;
          raddr_b = rs2_q;
          state_d = DATA;
        end
      end
      DATA: begin
        capture_en = 1'b1;
        state_d    = OUT;
      end
      OUT: begin
        if (bus.op_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      rd_we_q   <= 1'b0;
    end else if (latch_en) begin
      rs1_q     <= bus.rs1_i;
      rs2_q     <= bus.rs2_i;
      rd_q      <= bus.rd_i;
      use_rs1_q <= bus.use_rs1_i;
      use_rs2_q <= bus.use_rs2_i;
      rd_we_q   <= bus.rd_we_i;
    end
  end

  // Set is applied after clear so a same-cycle set/clear leaves the bit set;
  // the hazard above reads busy_q, i.e. before this instruction's own set.
  always_comb begin
    busy_d = busy_q;
    if (bus.wb_valid_i) busy_d[bus.wb_addr_i] = 1'b0;
    if (go && rd_we_q && (rd_q != '0)) busy_d[rd_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_rd_we_q <= 1'b0;
    end else if (capture_en) begin
      op_a_q     <= rs1_live ? bus.rdata_a_i : '0;
      op_b_q     <= rs2_live ? bus.rdata_b_i : '0;
      op_rd_q    <= rd_q;
      op_rd_we_q <= rd_we_q;
    end
  end

  assign bus.issue_ready_o = ready && rst_ni;
  assign bus.re_a_o        = re_a;
  assign bus.re_b_o        = re_b;
  assign bus.raddr_a_o     = raddr_a;
  assign bus.raddr_b_o     = raddr_b;
  assign bus.op_valid_o    = (state_q == OUT);
  assign bus.op_a_o        = op_a_q;
  assign bus.op_b_o        = op_b_q;
  assign bus.op_rd_o       = op_rd_q;
  assign bus.op_rd_we_o    = op_rd_we_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a registered register-bank model and
// a queue of expected operand bundles.
module tb_operand_fetch;
  localparam int NUMREGS   = 32;
  localparam int DATAWIDTH = 32;
  localparam int AW        = $clog2(NUMREGS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bank_rst_n = 1'b0;
  logic [DATAWIDTH-1:0] wb_data;
  logic [DATAWIDTH-1:0] bank [NUMREGS];

  always #5 clk = ~clk;

  operand_fetch_if #(.NUMREGS(NUMREGS), .DATAWIDTH(DATAWIDTH)) bus ();

  operand_fetch #(.NUMREGS(NUMREGS), .DATAWIDTH(DATAWIDTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Registered-read bank with write-to-read bypass.
  always @(posedge clk or negedge bank_rst_n) begin
    if (!bank_rst_n) begin
      for (int i = 0; i < NUMREGS; i++) bank[i] <= 32'(i);
      bus.rdata_a_i <= '0;
      bus.rdata_b_i <= '0;
    end else begin
      if (bus.re_a_o)
        bus.rdata_a_i <= (bus.wb_valid_i && bus.wb_addr_i == bus.raddr_a_o) ? wb_data : bank[bus.raddr_a_o];
      if (bus.re_b_o)
        bus.rdata_b_i <= (bus.wb_valid_i && bus.wb_addr_i == bus.raddr_b_o) ? wb_data : bank[bus.raddr_b_o];
      if (bus.wb_valid_i) bank[bus.wb_addr_i] <= wb_data;
    end
  end

  typedef struct {
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
    logic [AW-1:0]        rd;
    logic                 we;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                      input logic u1, input logic u2,
                      input logic [AW-1:0] d, input logic we,
                      input logic [31:0] ea, input logic [31:0] eb, input bit push);
    exp_t e;
    bus.issue_valid_i = 1'b1;
    bus.rs1_i = r1;  bus.rs2_i = r2;
    bus.use_rs1_i = u1;  bus.use_rs2_i = u2;
    bus.rd_i = d;  bus.rd_we_i = we;
    if (push) begin
      e.a = ea;  e.b = eb;  e.rd = d;  e.we = we;
      sb.push_back(e);
    end
    tick();
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic wait_op(input int budget, output int cycles);
    cycles = 0;
    while (bus.op_valid_o !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("op_valid_seen", 32'(bus.op_valid_o), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL %s_pending observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_op_a"},  bus.op_a_o, e.a);
      chk({tag, "_op_b"},  bus.op_b_o, e.b);
      chk({tag, "_op_rd"}, 32'(bus.op_rd_o), 32'(e.rd));
      chk({tag, "_op_we"}, 32'(bus.op_rd_we_o), 32'(e.we));
    end
  endtask

  initial begin
    bus.issue_valid_i = 1'b0;
    bus.rs1_i = '0;  bus.rs2_i = '0;
    bus.use_rs1_i = 1'b0;  bus.use_rs2_i = 1'b0;
    bus.rd_i = '0;  bus.rd_we_i = 1'b0;
    bus.wb_valid_i = 1'b0;  bus.wb_addr_i = '0;
    bus.op_ready_i = 1'b1;
    wb_data = '0;

    // Reset state
    tick();
    tick();
    chk("rst_issue_ready", 32'(bus.issue_ready_o), 0);
    chk("rst_op_valid",    32'(bus.op_valid_o), 0);
    chk("rst_re_a",        32'(bus.re_a_o), 0);
    chk("rst_re_b",        32'(bus.re_b_o), 0);
    chk("rst_op_a",        bus.op_a_o, 0);
    chk("rst_op_rd",       32'(bus.op_rd_o), 0);
    rst_n = 1'b1;
    bank_rst_n = 1'b1;
    #1;
    chk("idle_issue_ready", 32'(bus.issue_ready_o), 1);

    // Basic fetch: x3, x5 -> x7, latency and single-cycle read pulse
    send(3, 5, 1, 1, 7, 1, 32'd3, 32'd5, 1);
    chk("t1_re_a",    32'(bus.re_a_o), 1);
    chk("t1_re_b",    32'(bus.re_b_o), 1);
    chk("t1_raddr_a", 32'(bus.raddr_a_o), 3);
    chk("t1_raddr_b", 32'(bus.raddr_b_o), 5);
    chk("t1_ready_lo", 32'(bus.issue_ready_o), 0);
    tick();
    chk("t1_re_a_pulse", 32'(bus.re_a_o), 0);
    chk("t1_re_b_pulse", 32'(bus.re_b_o), 0);
    chk("t1_valid_early", 32'(bus.op_valid_o), 0);
    tick();
    chk("t1_valid_t3", 32'(bus.op_valid_o), 1);
    pop_check("t1");
    chk("t1_busy7", 32'(dut.busy_q[7]), 1);
    tick();
    chk("t1_valid_drop", 32'(bus.op_valid_o), 0);
    chk("t1_ready_back", 32'(bus.issue_ready_o), 1);

    // RAW hazard on x7, released by a writeback four cycles later
    send(7, 5, 1, 0, 10, 0, 32'hDEADBEEF, 32'd0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_stall_re_a", 32'(bus.re_a_o), 0);
      chk("t2_stall_re_b", 32'(bus.re_b_o), 0);
      tick();
    end
    bus.wb_valid_i = 1'b1;
    bus.wb_addr_i  = 7;
    wb_data        = 32'hDEADBEEF;
    #1;
    chk("t2_release_re_a",  32'(bus.re_a_o), 1);
    chk("t2_release_raddr", 32'(bus.raddr_a_o), 7);
    tick();
    bus.wb_valid_i = 1'b0;
    chk("t2_busy7_clear", 32'(dut.busy_q[7]), 0);
    wait_op(4, cyc);
    chk("t2_data_to_out", 32'(cyc), 1);
    pop_check("t2");
    tick();

    // Same-cycle resolve on x9
    send(1, 2, 1, 1, 9, 1, 32'd1, 32'd2, 1);
    wait_op(4, cyc);
    chk("t3a_latency", 32'(cyc), 2);
    pop_check("t3a");
    chk("t3_busy9_set", 32'(dut.busy_q[9]), 1);
    tick();
    send(0, 9, 0, 1, 0, 0, 32'd0, 32'h12345678, 1);
    bus.wb_valid_i = 1'b1;
    bus.wb_addr_i  = 9;
    wb_data        = 32'h12345678;
    #1;
    chk("t3_no_stall_re_b", 32'(bus.re_b_o), 1);
    chk("t3_raddr_b",       32'(bus.raddr_b_o), 9);
    chk("t3_unused_re_a",   32'(bus.re_a_o), 0);
    tick();
    bus.wb_valid_i = 1'b0;
    chk("t3_busy9_clear", 32'(dut.busy_q[9]), 0);
    wait_op(4, cyc);
    chk("t3b_data_to_out", 32'(cyc), 1);
    pop_check("t3b");
    tick();

    // Backpressure: five cycles held in OUT
    bus.op_ready_i = 1'b0;
    send(3, 5, 1, 1, 11, 1, 32'd3, 32'd5, 1);
    wait_op(4, cyc);
    chk("t4_latency", 32'(cyc), 2);
    pop_check("t4");
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(bus.op_valid_o), 1);
      chk("t4_hold_ready", 32'(bus.issue_ready_o), 0);
      chk("t4_hold_op_a",  bus.op_a_o, 32'd3);
      chk("t4_hold_op_b",  bus.op_b_o, 32'd5);
      chk("t4_hold_op_rd", 32'(bus.op_rd_o), 11);
      if (i < 4) tick();
    end
    bus.op_ready_i = 1'b1;
    tick();
    chk("t4_ready_after", 32'(bus.issue_ready_o), 1);
    chk("t4_valid_after", 32'(bus.op_valid_o), 0);

    // x0: bank[0] holds junk, operand must still read as zero
    bus.wb_valid_i = 1'b1;
    bus.wb_addr_i  = 0;
    wb_data        = 32'hFFFF0000;
    tick();
    bus.wb_valid_i = 1'b0;
    send(0, 0, 1, 0, 0, 1, 32'd0, 32'd0, 1);
    chk("t5_re_a",    32'(bus.re_a_o), 1);
    chk("t5_re_b",    32'(bus.re_b_o), 0);
    chk("t5_raddr_a", 32'(bus.raddr_a_o), 0);
    wait_op(4, cyc);
    chk("t5_latency", 32'(cyc), 2);
    pop_check("t5");
    chk("t5_busy0", 32'(dut.busy_q[0]), 0);
    tick();

    // Reset while stalled on x4
    send(1, 2, 1, 1, 4, 1, 32'd1, 32'd2, 1);
    wait_op(4, cyc);
    pop_check("t6a");
    tick();
    chk("t6_busy4_set", 32'(dut.busy_q[4]), 1);
    send(4, 0, 1, 0, 0, 0, 32'd0, 32'd0, 0);
    tick();
    chk("t6_stall_re_a", 32'(bus.re_a_o), 0);
    chk("t6_stall_valid", 32'(bus.op_valid_o), 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready",  32'(bus.issue_ready_o), 0);
    chk("t6_rst_op_a",   bus.op_a_o, 0);
    chk("t6_rst_op_b",   bus.op_b_o, 0);
    chk("t6_rst_op_rd",  32'(bus.op_rd_o), 0);
    chk("t6_rst_op_we",  32'(bus.op_rd_we_o), 0);
    chk("t6_rst_busy4",  32'(dut.busy_q[4]), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_post_ready", 32'(bus.issue_ready_o), 1);
    send(4, 0, 1, 0, 0, 0, 32'd4, 32'd0, 1);
    chk("t6_no_stall_re_a", 32'(bus.re_a_o), 1);
    wait_op(4, cyc);
    chk("t6_latency", 32'(cyc), 2);
    pop_check("t6b");
    tick();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
